// File: rtl/rat.sv
// Register alias table: per-register rename state plus the architectural file,
// with two zero-latency source lookups that bypass same-cycle writeback and commit.

package rat_pkg;
    typedef enum logic [1:0] {
        ST_COMMITTED = 2'd0,
        ST_PENDING   = 2'd1,
        ST_WRITTEN   = 2'd2
    } ent_state_t;
endpackage

// One architectural register: rename state, in-flight tag, speculative and committed values.
module rat_entry
    import rat_pkg::*;
#(
    parameter int TAGW = 7,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alloc_we,
    input  logic [TAGW-1:0] alloc_tag,
    input  logic            commit_we,
    input  logic [TAGW-1:0] commit_tag,
    input  logic [XLEN-1:0] commit_value,
    input  logic            wb_valid,
    input  logic [TAGW-1:0] wb_robid,
    input  logic [XLEN-1:0] wb_result,
    input  logic            flush,
    output ent_state_t      state,
    output logic [TAGW-1:0] tag,
    output logic [XLEN-1:0] spec,
    output logic [XLEN-1:0] arch
);
    ent_state_t      state_q, state_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [XLEN-1:0] spec_q, spec_d;
    logic [XLEN-1:0] arch_q, arch_d;

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        spec_d  = spec_q;
        arch_d  = arch_q;
        // Retiring value always lands in the architectural file, even under flush.
        if (commit_we)
            arch_d = commit_value;
        if (flush) begin
            state_d = ST_COMMITTED;
        end else if (alloc_we) begin
            state_d = ST_PENDING;
            tag_d   = alloc_tag;
        end else if (commit_we && state_q != ST_COMMITTED && tag_q == commit_tag) begin
            state_d = ST_COMMITTED;
        end else if (wb_valid && state_q == ST_PENDING && tag_q == wb_robid) begin
            state_d = ST_WRITTEN;
            spec_d  = wb_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_COMMITTED;
            tag_q   <= '0;
            spec_q  <= '0;
            arch_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            spec_q  <= spec_d;
            arch_q  <= arch_d;
        end
    end

    assign state = state_q;
    assign tag   = tag_q;
    assign spec  = spec_q;
    assign arch  = arch_q;
endmodule

// Combinational source lookup with writeback and commit bypass.
module rat_read
    import rat_pkg::*;
#(
    parameter int NREG = 32,
    parameter int TAGW = 7,
    parameter int XLEN = 32,
    parameter int IDXW = $clog2(NREG)
) (
    input  logic [IDXW-1:0]            idx,
    input  ent_state_t [NREG-1:0]      states,
    input  logic [NREG-1:0][TAGW-1:0]  tags,
    input  logic [NREG-1:0][XLEN-1:0]  specs,
    input  logic [NREG-1:0][XLEN-1:0]  archs,
    input  logic                       wb_valid,
    input  logic [TAGW-1:0]            wb_robid,
    input  logic [XLEN-1:0]            wb_result,
    input  logic                       rob_commit,
    input  logic [IDXW-1:0]            rob_commit_rd,
    input  logic [TAGW-1:0]            rob_commit_robid,
    input  logic [XLEN-1:0]            rob_commit_value,
    output logic                       valid,
    output logic [XLEN-1:0]            tagval
);
    ent_state_t      st;
    logic [TAGW-1:0] tg;

    always_comb begin
        st     = states[idx];
        tg     = tags[idx];
        valid  = 1'b1;
        tagval = archs[idx];
        if (idx == '0)
            tagval = '0;
        else if (wb_valid && st == ST_PENDING && wb_robid == tg)
            tagval = wb_result;
        else if (rob_commit && rob_commit_rd == idx && st == ST_PENDING && tg == rob_commit_robid)
            tagval = rob_commit_value;
        else if (st == ST_WRITTEN)
            tagval = specs[idx];
        else if (st == ST_PENDING) begin
            valid  = 1'b0;
            tagval = XLEN'(tg);
        end
    end
endmodule

module rat
    import rat_pkg::*;
#(
    parameter int NREG = 32,
    parameter int TAGW = 7,
    parameter int XLEN = 32,
    parameter int IDXW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IDXW-1:0] rename_rs1,
    input  logic [IDXW-1:0] rename_rs2,
    input  logic            rename_alloc,
    input  logic [IDXW:0]   rename_rd,
    input  logic [TAGW-1:0] rename_robid,
    output logic            rat_rs1_valid,
    output logic [XLEN-1:0] rat_rs1_tagval,
    output logic            rat_rs2_valid,
    output logic [XLEN-1:0] rat_rs2_tagval,
    input  logic            wb_valid,
    input  logic [TAGW-1:0] wb_robid,
    input  logic [XLEN-1:0] wb_result,
    input  logic            rob_commit,
    input  logic [IDXW-1:0] rob_commit_rd,
    input  logic [TAGW-1:0] rob_commit_robid,
    input  logic [XLEN-1:0] rob_commit_value,
    input  logic            rob_flush
);
    ent_state_t [NREG-1:0]     states;
    logic [NREG-1:0][TAGW-1:0] tags;
    logic [NREG-1:0][XLEN-1:0] specs;
    logic [NREG-1:0][XLEN-1:0] archs;
    logic [NREG-1:0]           alloc_we;
    logic [NREG-1:0]           commit_we;

    // x0 never allocates or commits, so its entry stays COMMITTED at zero.
    for (genvar i = 0; i < NREG; i++) begin : g_ent
        assign alloc_we[i]  = (i != 0) && rename_alloc && !rename_rd[IDXW] &&
                              rename_rd[IDXW-1:0] == IDXW'(i) && !rob_flush;
        assign commit_we[i] = (i != 0) && rob_commit && rob_commit_rd == IDXW'(i);

        rat_entry #(.TAGW(TAGW), .XLEN(XLEN)) u_ent (
            .clk          (clk),
            .rst          (rst),
            .alloc_we     (alloc_we[i]),
            .alloc_tag    (rename_robid),
            .commit_we    (commit_we[i]),
            .commit_tag   (rob_commit_robid),
            .commit_value (rob_commit_value),
            .wb_valid     (wb_valid),
            .wb_robid     (wb_robid),
            .wb_result    (wb_result),
            .flush        (rob_flush),
            .state        (states[i]),
            .tag          (tags[i]),
            .spec         (specs[i]),
            .arch         (archs[i])
        );
    end

    logic [1:0][IDXW-1:0] rd_idx;
    logic [1:0]           rd_valid;
    logic [1:0][XLEN-1:0] rd_tagval;

    assign rd_idx[0] = rename_rs1;
    assign rd_idx[1] = rename_rs2;

    for (genvar p = 0; p < 2; p++) begin : g_rd
        rat_read #(.NREG(NREG), .TAGW(TAGW), .XLEN(XLEN), .IDXW(IDXW)) u_rd (
            .idx              (rd_idx[p]),
            .states           (states),
            .tags             (tags),
            .specs            (specs),
            .archs            (archs),
            .wb_valid         (wb_valid),
            .wb_robid         (wb_robid),
            .wb_result        (wb_result),
            .rob_commit       (rob_commit),
            .rob_commit_rd    (rob_commit_rd),
            .rob_commit_robid (rob_commit_robid),
            .rob_commit_value (rob_commit_value),
            .valid            (rd_valid[p]),
            .tagval           (rd_tagval[p])
        );
    end

    assign rat_rs1_valid  = rd_valid[0];
    assign rat_rs1_tagval = rd_tagval[0];
    assign rat_rs2_valid  = rd_valid[1];
    assign rat_rs2_tagval = rd_tagval[1];
endmodule
